pe_output_requantizer: RTL and testbench
========================================

Name: pe_output_requantizer

Overview:
Downstream stage of the signed 8x8 MAC processing element. Captures each 32-bit accumulator result on the PE's done pulse, adds a per-channel bias, applies a rounding arithmetic right shift and saturates to int8. Results are queued in a small FIFO and drained over a valid/ready interface toward the feature-map writer. The PE cannot be stalled, so the block owns admission control and reports dropped results.

Parameters:
FIFO_DEPTH, 4, output queue entries (power of two, 2..16)
CNT_W, 8, width of saturating drop counter

Ports:
clk  input  1  system clock, all logic on rising edge
i_reset  input  1  synchronous active-high reset
i_result  input  32  signed accumulator value from PE (o_result)
i_overflow  input  1  PE overflow flag, qualified by i_done
i_done  input  1  one-cycle pulse: i_result/i_overflow valid
i_bias  input  32  signed bias, sampled with i_done
i_shift  input  5  right-shift amount 0..31, sampled with i_done
o_data  output  8  signed int8 result at FIFO head
o_sat  output  1  head entry was saturated (range or PE overflow)
o_valid  output  1  FIFO non-empty
i_ready  input  1  consumer accepts head when o_valid&i_ready
o_drop  output  1  one-cycle pulse: i_done rejected
o_drop_cnt  output  CNT_W  saturating count of rejected results
o_busy  output  1  any pipeline stage valid or FIFO non-empty

Behaviour:
- Reset (sync, i_reset=1 at edge): all stage valids cleared, FIFO emptied, o_data=0, o_sat=0, o_valid=0, o_drop=0, o_drop_cnt=0, o_busy=0. Reset mid-operation discards all in-flight and queued results; no output until new i_done.
- Admission: credit = FIFO_DEPTH - fifo_count - s1_v - s2_v, evaluated on current-cycle state; a pop in the same cycle is NOT credited. i_done with credit>0 -> accepted into S1. i_done with credit==0 -> o_drop=1 next cycle, o_drop_cnt += 1 (holds at 2^CNT_W-1).
- S1 (edge 1): register i_result, i_bias, i_shift, i_overflow; s1_v=1.
- S2 (edge 2): sum = sext33(result) + sext33(bias); carry ovf, shift.
- S3 (edge 3): if shift==0 q=sum; else q = (sum + 2^(shift-1)) >>> shift, computed at 34 bits (round half up toward +inf). Saturate q to [-128,127]; sat=1 if clamped. If ovf=1: output = 127 when result[31]==1, else -128 (accumulator wrap inverts sign); sat=1. Push {data,sat} into FIFO.
- Latency: i_done at edge N -> o_valid=1 after edge N+3 when FIFO was empty.
- Throughput: one accepted result per cycle; back-to-back i_done allowed.
- FIFO: first-word-fall-through; o_data/o_sat show head, undefined content not allowed -> hold 0 when empty. Pop on o_valid&i_ready. Push and pop same cycle: count unchanged. Credit scheme guarantees push never hits full.
- Stages advance unconditionally (no stall); back-pressure only via admission.
- o_busy = s1_v | s2_v | (fifo_count!=0).

Optional Feature:
Macro REQUANT_RELU_EN. Defined: after saturation, negative results forced to 0 (including ovf case giving -128); sat flag unchanged by ReLU. Undefined: full signed int8 output range [-128,127].

Test Plan:
- Reset then i_done, result=1000, bias=24, shift=3, i_ready=1 -> o_valid after 3 edges, o_data=(1024+4)>>3=128 -> clamped 127, o_sat=1.
- result=-300, bias=0, shift=2 -> (-300+2)>>>2=-75 (0x B5), o_sat=0; with REQUANT_RELU_EN -> 0.
- result=0x7FFFFFF0, i_overflow=1 -> o_data=-128, o_sat=1 (0 under REQUANT_RELU_EN).
- i_ready=0, FIFO_DEPTH=4, six consecutive i_done -> first 4 accepted, 5th and 6th give o_drop pulses, o_drop_cnt=2; then i_ready=1 drains exactly 4 entries in order.
- Continuous i_done with i_ready=1 every cycle, 20 results -> 20 outputs, no drops, one output per cycle after 3-cycle fill.
- Assert i_reset with 2 results in pipeline and 3 in FIFO -> next cycle o_valid=0, o_busy=0, o_drop_cnt=0; subsequent single i_done produces exactly one output.

Source files
------------

// File: rtl/pe_output_requantizer.sv
// rtl/pe_output_requantizer.sv - bias add, rounding shift and int8 saturation of PE results with FWFT output queue
// Optional macro REQUANT_RELU_EN clamps negative outputs to zero after saturation.
module pe_output_requantizer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic [31:0]      i_result,
  input  logic             i_overflow,
  input  logic             i_done,
  input  logic [31:0]      i_bias,
  input  logic [4:0]       i_shift,
  output logic [7:0]       o_data,
  output logic             o_sat,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_drop,
  output logic [CNT_W-1:0] o_drop_cnt,
  output logic             o_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic              s1_v, s1_ovf;
  logic [31:0]       s1_result, s1_bias;
  logic [4:0]        s1_shift;
  logic              s2_v, s2_ovf, s2_sign;
  logic [32:0]       s2_sum;
  logic [4:0]        s2_shift;

  logic [8:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_count;

  logic [CW:0]       occ;
  logic              accept, push, pop;

  // Every admitted result owns a slot until popped; a same-cycle pop is not credited.
  assign occ    = {1'b0, fifo_count} + (CW+1)'(s1_v) + (CW+1)'(s2_v);
  assign accept = i_done && (occ < (CW+1)'(FIFO_DEPTH));
  assign push   = s2_v;
  assign pop    = o_valid && i_ready;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      s1_v       <= 1'b0;
      s2_v       <= 1'b0;
      o_drop     <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      s1_v   <= accept;
      s2_v   <= s1_v;
      o_drop <= i_done && !accept;
      if (i_done && !accept && (o_drop_cnt != '1))
        o_drop_cnt <= o_drop_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_result <= i_result;
      s1_bias   <= i_bias;
      s1_shift  <= i_shift;
      s1_ovf    <= i_overflow;
    end
    s2_sum   <= {s1_result[31], s1_result} + {s1_bias[31], s1_bias};
    s2_sign  <= s1_result[31];
    s2_shift <= s1_shift;
    s2_ovf   <= s1_ovf;
  end

  logic signed [33:0] sum_x, q;
  logic [33:0]        rnd;
  logic [7:0]         q_data;
  logic               q_sat;

  always_comb begin
    sum_x  = {s2_sum[32], s2_sum};
    rnd    = (s2_shift == 5'd0) ? 34'd0 : (34'd1 << (s2_shift - 5'd1));
    q      = $signed(sum_x + rnd) >>> s2_shift;
    q_data = q[7:0];
    q_sat  = 1'b0;
    if (s2_ovf) begin
      // A wrapped accumulator shows the opposite sign of the true value.
      q_data = s2_sign ? 8'h7F : 8'h80;
      q_sat  = 1'b1;
    end else if (q > 34'sd127) begin
      q_data = 8'h7F;
      q_sat  = 1'b1;
    end else if (q < -34'sd128) begin
      q_data = 8'h80;
      q_sat  = 1'b1;
    end
`ifdef REQUANT_RELU_EN
    if (q_data[7])
      q_data = 8'h00;
`endif
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {q_sat, q_data};
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        fifo_count <= fifo_count + CW'(1);
      else if (pop && !push)
        fifo_count <= fifo_count - CW'(1);
    end
  end

  assign o_valid = (fifo_count != '0);
  assign o_data  = o_valid ? mem[rd_ptr][7:0] : 8'h00;
  assign o_sat   = o_valid ? mem[rd_ptr][8]   : 1'b0;
  assign o_busy  = s1_v || s2_v || o_valid;

endmodule

// File: tb/tb_pe_output_requantizer.sv
// tb/tb_pe_output_requantizer.sv - randomized and directed bench for pe_output_requantizer
// Reference model tracks every admitted result as an outstanding slot with its arrival cycle.
module tb_pe_output_requantizer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        i_reset, i_overflow, i_done, i_ready;
  logic [31:0] i_result, i_bias;
  logic [4:0]  i_shift;
  logic [7:0]  o_data;
  logic        o_sat, o_valid, o_drop, o_busy;
  logic [7:0]  o_drop_cnt;

  pe_output_requantizer #(.FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .i_reset(i_reset), .i_result(i_result), .i_overflow(i_overflow),
    .i_done(i_done), .i_bias(i_bias), .i_shift(i_shift), .o_data(o_data),
    .o_sat(o_sat), .o_valid(o_valid), .i_ready(i_ready), .o_drop(o_drop),
    .o_drop_cnt(o_drop_cnt), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] v;
    int         avail;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   pops = 0;
  int   exp_cnt = 0;
  bit   exp_drop = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ref_q(input int res, input int bias, input int sh, input bit ovf);
    longint sum, n, d, r;
    logic [7:0] data;
    bit sat;
    sum = longint'(res) + longint'(bias);
    sat = 0;
    if (ovf) begin
      r = (res < 0) ? 127 : -128;
      sat = 1;
    end else begin
      if (sh == 0) r = sum;
      else begin
        d = longint'(1) << sh;
        n = sum + d / 2;
        r = n / d;
        if ((n % d != 0) && (n < 0)) r = r - 1;
      end
      if (r > 127) begin r = 127; sat = 1; end
      if (r < -128) begin r = -128; sat = 1; end
    end
`ifdef REQUANT_RELU_EN
    if (r < 0) r = 0;
`endif
    data = r[7:0];
    return {sat, data};
  endfunction

  task automatic step(input bit done, input int res, input int bias, input int sh,
                      input bit ovf, input bit rdy);
    bit exp_valid;
    int occ;
    ent_t e;
    i_done = done; i_result = res; i_bias = bias; i_shift = sh[4:0];
    i_overflow = ovf; i_ready = rdy;
    exp_valid = (q.size() > 0) && (q[0].avail <= cyc);
    check("valid", {31'd0, o_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      check("data", {24'd0, o_data}, {24'd0, q[0].v[7:0]});
      check("sat", {31'd0, o_sat}, {31'd0, q[0].v[8]});
    end else begin
      check("data_empty", {24'd0, o_data}, 32'd0);
      check("sat_empty", {31'd0, o_sat}, 32'd0);
    end
    check("busy", {31'd0, o_busy}, {31'd0, q.size() > 0});
    check("drop", {31'd0, o_drop}, {31'd0, exp_drop});
    check("drop_cnt", {24'd0, o_drop_cnt}, exp_cnt);
    occ = q.size();
    if (exp_valid && rdy) begin
      void'(q.pop_front());
      pops++;
    end
    exp_drop = 0;
    if (done) begin
      if (occ < DEPTH) begin
        e.v = ref_q(res, bias, sh, ovf);
        e.avail = cyc + 3;
        q.push_back(e);
      end else begin
        exp_drop = 1;
        if (exp_cnt < 255) exp_cnt++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, rdy);
  endtask

  function automatic int rand_val();
    if ($urandom_range(0, 3) == 0) return int'($urandom);
    return int'($urandom_range(0, 4000)) - 2000;
  endfunction

  function automatic int rand_shift();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 31));
    return int'($urandom_range(0, 5));
  endfunction

  task automatic do_reset();
    i_reset = 1; i_done = 0; i_ready = 0;
    @(posedge clk);
    #1;
    cyc++;
    i_reset = 0;
    q.delete();
    exp_cnt = 0;
    exp_drop = 0;
  endtask

  initial begin
    i_reset = 1; i_done = 0; i_ready = 0; i_result = 0; i_bias = 0;
    i_shift = 0; i_overflow = 0;
    repeat (2) @(posedge clk);
    #1;
    i_reset = 0;
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_data", {24'd0, o_data}, 32'd0);
    check("rst_sat", {31'd0, o_sat}, 32'd0);
    check("rst_drop", {31'd0, o_drop}, 32'd0);
    check("rst_cnt", {24'd0, o_drop_cnt}, 32'd0);

    // Test-plan vectors held in the queue, then popped one by one.
    step(1, 1000, 24, 3, 0, 0);
    step(1, -300, 0, 2, 0, 0);
    step(1, 32'h7FFFFFF0, 0, 0, 1, 0);
    idle(2, 0);
    check("tp1_data", {24'd0, o_data}, 32'h7F);
    check("tp1_sat", {31'd0, o_sat}, 32'd1);
    idle(1, 1);
`ifdef REQUANT_RELU_EN
    check("tp2_data", {24'd0, o_data}, 32'h00);
`else
    check("tp2_data", {24'd0, o_data}, 32'hB5);
`endif
    check("tp2_sat", {31'd0, o_sat}, 32'd0);
    idle(1, 1);
`ifdef REQUANT_RELU_EN
    check("tp3_data", {24'd0, o_data}, 32'h00);
`else
    check("tp3_data", {24'd0, o_data}, 32'h80);
`endif
    check("tp3_sat", {31'd0, o_sat}, 32'd1);
    idle(2, 1);

    // Six results against a stalled consumer.
    for (int k = 0; k < 6; k++) step(1, rand_val(), rand_val(), rand_shift(), 0, 0);
    idle(3, 0);
    check("drop_two", {24'd0, o_drop_cnt}, 32'd2);
    pops = 0;
    idle(6, 1);
    check("drain_four", pops, 32'd4);

    // Back-to-back stream with a free-running consumer.
    pops = 0;
    for (int k = 0; k < 20; k++) step(1, rand_val(), rand_val(), rand_shift(), 0, 1);
    idle(5, 1);
    check("stream_pops", pops, 32'd20);
    check("stream_nodrop", {24'd0, o_drop_cnt}, 32'd2);

    for (int k = 0; k < 300; k++)
      step($urandom_range(0, 2) != 0, rand_val(), rand_val(), rand_shift(),
           $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
    idle(8, 1);

    // Reset with two results in the pipeline and three queued.
    for (int k = 0; k < 3; k++) step(1, rand_val(), rand_val(), rand_shift(), 0, 0);
    idle(2, 0);
    for (int k = 0; k < 2; k++) step(1, rand_val(), rand_val(), rand_shift(), 0, 0);
    do_reset();
    check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    check("mid_rst_cnt", {24'd0, o_drop_cnt}, 32'd0);
    pops = 0;
    step(1, rand_val(), rand_val(), rand_shift(), 0, 1);
    idle(6, 1);
    check("post_rst_one", pops, 32'd1);

    for (int k = 0; k < 300; k++) step(1, rand_val(), rand_val(), rand_shift(), 0, 0);
    idle(1, 0);
    check("cnt_saturate", {24'd0, o_drop_cnt}, 32'hFF);
    idle(8, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
